custom_bw_spram: RTL and testbench

CUSTOM_BW_SPRAM -- requirements
Module: custom_bw_spram

---
 rtl/custom_bw_spram.sv | 124 ++++++++++++
 tb/tb_custom_bw_spram.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_bw_spram.sv
// Byte-lane writable single-port RAM with a fully pipelined access path of P_READ_LATENCY cycles.
// Accepts one access every cycle and never stalls; out-of-range accesses return zero and raise addr_err.
module custom_bw_spram #(
  parameter int                    P_DATA_WIDTH   = 32,
  parameter int                    P_BYTE_WIDTH   = 8,
  parameter int                    P_DEPTH        = 64,
  parameter int                    P_ADDR_WIDTH   = 6,
  parameter int                    P_READ_LATENCY = 2,
  parameter int                    P_WRITE_MODE   = 0,
  parameter logic [P_DATA_WIDTH-1:0] P_RESET_VALUE = '0,
  localparam int                   NB             = P_DATA_WIDTH / P_BYTE_WIDTH
) (
  input  logic                    clka,
  input  logic                    rsta_n,
  input  logic                    ena,
  input  logic [NB-1:0]           wea,
  input  logic [P_ADDR_WIDTH-1:0] addra,
  input  logic [P_DATA_WIDTH-1:0] dina,
  output logic [P_DATA_WIDTH-1:0] douta,
  output logic                    douta_vld,
  output logic                    addr_err
);

  localparam int                  NS        = P_READ_LATENCY - 1;
  localparam logic [P_ADDR_WIDTH:0] DEPTH_LIM = (P_ADDR_WIDTH+1)'(P_DEPTH);

  logic [P_DATA_WIDTH-1:0] mem_q [P_DEPTH];

  logic                    in_range;
  logic                    is_wr;
  logic                    acc_vld;
  logic                    acc_err;
  logic [P_DATA_WIDTH-1:0] rd_word;
  logic [P_DATA_WIDTH-1:0] mrg_word;
  logic [P_DATA_WIDTH-1:0] acc_dat;

  logic                    res_vld;
  logic                    res_err;
  logic [P_DATA_WIDTH-1:0] res_dat;

  logic [P_DATA_WIDTH-1:0] douta_q, douta_d;
  logic                    douta_vld_q, douta_vld_d;
  logic                    addr_err_q, addr_err_d;

  // The array is read before the edge, so a read-first result is the pre-write word
  // and a write at edge N is visible to a read at edge N+1.
  always_comb begin
    in_range = ({1'b0, addra} < DEPTH_LIM);
    is_wr    = |wea;
    rd_word  = in_range ? mem_q[addra] : '0;
    mrg_word = rd_word;
    for (int b = 0; b < NB; b++) begin
      if (wea[b]) mrg_word[b*P_BYTE_WIDTH +: P_BYTE_WIDTH] = dina[b*P_BYTE_WIDTH +: P_BYTE_WIDTH];
    end
    acc_vld = ena & (~is_wr | (P_WRITE_MODE != 2));
    acc_err = ~in_range;
    if (!in_range)                      acc_dat = '0;
    else if (is_wr && P_WRITE_MODE == 1) acc_dat = mrg_word;
    else                                 acc_dat = rd_word;
  end

  always_ff @(posedge clka) begin
    if (ena && is_wr && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (wea[b]) mem_q[addra][b*P_BYTE_WIDTH +: P_BYTE_WIDTH] <= dina[b*P_BYTE_WIDTH +: P_BYTE_WIDTH];
      end
    end
  end

  if (NS == 0) begin : g_direct
    assign res_vld = acc_vld;
    assign res_err = acc_err;
    assign res_dat = acc_dat;
  end else begin : g_pipe
    logic [NS-1:0]           vld_q;
    logic [NS-1:0]           err_q;
    logic [P_DATA_WIDTH-1:0] dat_q [NS];

    always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
        vld_q <= '0;
        err_q <= '0;
        for (int i = 0; i < NS; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= acc_vld;
        err_q[0] <= acc_err;
        dat_q[0] <= acc_dat;
        for (int i = 1; i < NS; i++) begin
          vld_q[i] <= vld_q[i-1];
          err_q[i] <= err_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign res_vld = vld_q[NS-1];
    assign res_err = err_q[NS-1];
    assign res_dat = dat_q[NS-1];
  end

  // douta only moves when a result lands; empty slots leave it holding.
  always_comb begin
    douta_d     = res_vld ? res_dat : douta_q;
    douta_vld_d = res_vld;
    addr_err_d  = res_vld & res_err;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      douta_q     <= P_RESET_VALUE;
      douta_vld_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      douta_q     <= douta_d;
      douta_vld_q <= douta_vld_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign douta     = douta_q;
  assign douta_vld = douta_vld_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_custom_bw_spram.sv
// Bench for custom_bw_spram: six instances covering latencies 1..3, all write modes and a
// non-power-of-two depth, driven together and compared with a slot-scheduled reference model.
module tb_custom_bw_spram;

  localparam int NI = 6;
  localparam int LAT [NI]   = '{1, 2, 3, 2, 2, 2};
  localparam int MODE [NI]  = '{0, 0, 0, 1, 2, 0};
  localparam int DEPTH [NI] = '{64, 64, 64, 64, 64, 48};
  localparam logic [31:0] RSTV [NI] = '{32'h0, 32'h0, 32'h5A5AA5A5, 32'h0000FFFF, 32'h12345678, 32'h0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  wea;
  logic [5:0]  addra;
  logic [31:0] dina;
  logic [31:0] dout [NI];
  logic [NI-1:0] dvld;
  logic [NI-1:0] derr;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mem_m [NI][64];
  logic        sv [NI][8];
  logic        se [NI][8];
  logic [31:0] sd [NI][8];
  logic        cur_v [NI];
  logic        cur_e [NI];
  logic [31:0] last [NI];
  int          ecnt = 0;

  // per-test capture of outputs after each driven edge
  logic        hv [NI][16];
  logic        he [NI][16];
  logic [31:0] hd [NI][16];
  int          capn = 0;

  always #5 clk = ~clk;

  custom_bw_spram #(.P_READ_LATENCY(1)) u_l1 (
    .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[0]), .douta_vld(dvld[0]), .addr_err(derr[0]));
  custom_bw_spram u_l2 (
    .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[1]), .douta_vld(dvld[1]), .addr_err(derr[1]));
  custom_bw_spram #(.P_READ_LATENCY(3), .P_RESET_VALUE(32'h5A5AA5A5)) u_l3 (
    .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[2]), .douta_vld(dvld[2]), .addr_err(derr[2]));
  custom_bw_spram #(.P_WRITE_MODE(1), .P_RESET_VALUE(32'h0000FFFF)) u_m1 (
    .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[3]), .douta_vld(dvld[3]), .addr_err(derr[3]));
  custom_bw_spram #(.P_WRITE_MODE(2), .P_RESET_VALUE(32'h12345678)) u_m2 (
    .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[4]), .douta_vld(dvld[4]), .addr_err(derr[4]));
  custom_bw_spram #(.P_DEPTH(48)) u_d48 (
    .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[5]), .douta_vld(dvld[5]), .addr_err(derr[5]));

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ipat(input int a);
    return (32'(a) * 32'h01010101) ^ 32'hC0DE0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int s = 0; s < 8; s++) sv[i][s] = 1'b0;
      cur_v[i] = 1'b0;
      cur_e[i] = 1'b0;
      last[i]  = RSTV[i];
    end
  endtask

  // One access per call: schedule each instance's result LAT cycles ahead, then advance one edge.
  task automatic drive(input logic en, input logic [3:0] we, input logic [5:0] a, input logic [31:0] d);
    logic [31:0] old, mrg;
    logic        inr;
    int          s;
    ena = en; wea = we; addra = a; dina = d;
    for (int i = 0; i < NI; i++) begin
      inr = (int'(a) < DEPTH[i]);
      old = mem_m[i][a];
      mrg = merge(old, d, we);
      s   = (ecnt + LAT[i]) % 8;
      if (en && (we == 4'h0 || MODE[i] != 2)) begin
        sv[i][s] = 1'b1;
        se[i][s] = !inr;
        sd[i][s] = !inr ? 32'h0 : ((we == 4'h0 || MODE[i] == 0) ? old : mrg);
      end
      if (en && we != 4'h0 && inr) mem_m[i][a] = mrg;
    end
    @(posedge clk);
    ecnt++;
    #1;
    for (int i = 0; i < NI; i++) begin
      s = ecnt % 8;
      cur_v[i] = sv[i][s];
      cur_e[i] = sv[i][s] & se[i][s];
      if (sv[i][s]) last[i] = sd[i][s];
      sv[i][s] = 1'b0;
      if (capn < 16) begin
        hv[i][capn] = dvld[i];
        hd[i][capn] = dout[i];
        he[i][capn] = derr[i];
      end
    end
    capn++;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < NI; i++) begin
      checks++; if (dout[i] !== RSTV[i]) begin errors++; $display("FAIL reset_douta inst%0d got %h want %h", i, dout[i], RSTV[i]); end
      checks++; if (dvld[i] !== 1'b0) begin errors++; $display("FAIL reset_vld inst%0d got %b want 0", i, dvld[i]); end
      checks++; if (derr[i] !== 1'b0) begin errors++; $display("FAIL reset_err inst%0d got %b want 0", i, derr[i]); end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    for (int a = 0; a < 64; a++) drive(1'b1, 4'hF, 6'(a), ipat(a));
    for (int a = 0; a < 4; a++) drive(1'b1, 4'h0, 6'(a), 32'h0);
    for (int k = 0; k < 3; k++) drive(1'b0, 4'h0, 6'h0, 32'h0);
    for (int i = 0; i < NI; i++) begin
      checks++; if (dout[i] !== ipat(3)) begin errors++; $display("FAIL init_read inst%0d got %h want %h", i, dout[i], ipat(3)); end
    end
  endtask

  task automatic test_basic();
    capn = 0;
    drive(1'b1, 4'hF, 6'd5, 32'hDEADBEEF);
    drive(1'b1, 4'h0, 6'd5, 32'h0);
    for (int k = 0; k < 3; k++) drive(1'b0, 4'h0, 6'h0, 32'h0);
    for (int i = 0; i < NI; i++) begin
      checks++; if (hv[i][LAT[i]] !== 1'b1) begin errors++; $display("FAIL basic_vld inst%0d got %b want 1", i, hv[i][LAT[i]]); end
      checks++; if (hd[i][LAT[i]] !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data inst%0d got %h want deadbeef", i, hd[i][LAT[i]]); end
    end
    checks++; if (hd[1][1] !== ipat(5)) begin errors++; $display("FAIL basic_readfirst got %h want %h", hd[1][1], ipat(5)); end
    checks++; if (hv[1][3] !== 1'b0) begin errors++; $display("FAIL basic_single_vld got %b want 0", hv[1][3]); end
    checks++; if (hv[4][1] !== 1'b0) begin errors++; $display("FAIL basic_nochange_wslot got %b want 0", hv[4][1]); end
    checks++; if (hv[4][3] !== 1'b0) begin errors++; $display("FAIL basic_nochange_after got %b want 0", hv[4][3]); end
  endtask

  task automatic test_byte_merge();
    int k;
    capn = 0;
    drive(1'b1, 4'h0, 6'd9, 32'h0);
    drive(1'b1, 4'hF, 6'd9, 32'h11223344);
    drive(1'b1, 4'b0101, 6'd9, 32'hAABBCCDD);
    drive(1'b1, 4'h0, 6'd9, 32'h0);
    for (int j = 0; j < 3; j++) drive(1'b0, 4'h0, 6'h0, 32'h0);
    for (int i = 0; i < NI; i++) begin
      k = 2 + LAT[i] - 1;
      case (MODE[i])
        0: begin
          checks++; if (hd[i][k] !== 32'h11223344) begin errors++; $display("FAIL merge_rf_wslot inst%0d got %h want 11223344", i, hd[i][k]); end
        end
        1: begin
          checks++; if (hd[i][k] !== 32'h11BB33DD) begin errors++; $display("FAIL merge_wf_wslot inst%0d got %h want 11bb33dd", i, hd[i][k]); end
        end
        default: begin
          checks++; if (hv[i][k] !== 1'b0) begin errors++; $display("FAIL merge_nc_vld inst%0d got %b want 0", i, hv[i][k]); end
          checks++; if (hd[i][k] !== ipat(9)) begin errors++; $display("FAIL merge_nc_hold inst%0d got %h want %h", i, hd[i][k], ipat(9)); end
        end
      endcase
      checks++; if (hd[i][k+1] !== 32'h11BB33DD || hv[i][k+1] !== 1'b1) begin errors++; $display("FAIL merge_read inst%0d got %h/%b want 11bb33dd/1", i, hd[i][k+1], hv[i][k+1]); end
    end
  endtask

  task automatic test_out_of_range();
    capn = 0;
    drive(1'b1, 4'hF, 6'd50, 32'hFFFFFFFF);
    drive(1'b1, 4'h0, 6'd50, 32'h0);
    drive(1'b1, 4'h0, 6'd2, 32'h0);
    for (int j = 0; j < 3; j++) drive(1'b0, 4'h0, 6'h0, 32'h0);
    checks++; if ({hv[5][1], he[5][1], hd[5][1]} !== {2'b11, 32'h0}) begin errors++; $display("FAIL oor_wslot got vld=%b err=%b %h want 1 1 0", hv[5][1], he[5][1], hd[5][1]); end
    checks++; if ({hv[5][2], he[5][2], hd[5][2]} !== {2'b11, 32'h0}) begin errors++; $display("FAIL oor_read got vld=%b err=%b %h want 1 1 0", hv[5][2], he[5][2], hd[5][2]); end
    checks++; if ({hv[5][3], he[5][3], hd[5][3]} !== {2'b10, ipat(2)}) begin errors++; $display("FAIL oor_addr2 got vld=%b err=%b %h want 1 0 %h", hv[5][3], he[5][3], hd[5][3], ipat(2)); end
    checks++; if (he[5][4] !== 1'b0) begin errors++; $display("FAIL oor_err_idle got %b want 0", he[5][4]); end
    checks++; if ({he[1][2], hd[1][2]} !== {1'b0, 32'hFFFFFFFF}) begin errors++; $display("FAIL oor_inrange64 got err=%b %h want 0 ffffffff", he[1][2], hd[1][2]); end
  endtask

  task automatic test_reset_midpipe();
    drive(1'b1, 4'h0, 6'd1, 32'h0);
    drive(1'b1, 4'h0, 6'd2, 32'h0);
    rst_n = 1'b0;
    model_reset();
    ena = 1'b1; wea = 4'h0; addra = 6'd3;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++; if (dout[i] !== RSTV[i] || dvld[i] !== 1'b0 || derr[i] !== 1'b0) begin errors++; $display("FAIL midrst_assert inst%0d got %h/%b/%b want %h/0/0", i, dout[i], dvld[i], derr[i], RSTV[i]); end
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    capn = 0;
    for (int j = 0; j < 4; j++) drive(1'b0, 4'h0, 6'h0, 32'h0);
    drive(1'b1, 4'h0, 6'd1, 32'h0);
    for (int j = 0; j < 3; j++) drive(1'b0, 4'h0, 6'h0, 32'h0);
    for (int i = 0; i < NI; i++) begin
      checks++; if (hv[i][0] | hv[i][1] | hv[i][2] | hv[i][3]) begin errors++; $display("FAIL midrst_flush inst%0d got a result want none", i); end
      checks++; if (hd[i][3] !== RSTV[i]) begin errors++; $display("FAIL midrst_hold inst%0d got %h want %h", i, hd[i][3], RSTV[i]); end
      checks++; if (hd[i][4+LAT[i]-1] !== ipat(1) || hv[i][4+LAT[i]-1] !== 1'b1) begin errors++; $display("FAIL midrst_reread inst%0d got %h want %h", i, hd[i][4+LAT[i]-1], ipat(1)); end
    end
  endtask

  task automatic test_random();
    logic       en;
    logic [3:0] we;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
      end
      en = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      drive(en, we, 6'($urandom_range(0, 63)), $urandom);
      for (int i = 0; i < NI; i++) begin
        checks++; if (dvld[i] !== cur_v[i]) begin errors++; $display("FAIL rand_vld n%0d inst%0d got %b want %b", n, i, dvld[i], cur_v[i]); end
        checks++; if (dout[i] !== last[i]) begin errors++; $display("FAIL rand_data n%0d inst%0d got %h want %h", n, i, dout[i], last[i]); end
        checks++; if (derr[i] !== cur_e[i]) begin errors++; $display("FAIL rand_err n%0d inst%0d got %b want %b", n, i, derr[i], cur_e[i]); end
      end
    end
  endtask

  initial begin
    ena = 1'b0; wea = 4'h0; addra = 6'h0; dina = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_init();
    test_basic();
    test_byte_merge();
    test_out_of_range();
    test_reset_midpipe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
